adder_8u_bist_driver: RTL

Built-in self-test driver for the registered 8-bit adder wrappers (e.g. `adder_<topology>_8u_wrapper`). It sits directly on both sides of the adder wrapper. It generates pseudo-random operand pairs from a 16-bit LFSR and drives them onto the wrapper's `a`/`b` inputs, one pair per cycle. It then compares the returned `sum`/`cout`, after the wrapper's fixed pipeline latency, against a golden result it computes itself, and reports pass/fail, the error count and the index of the first failing vector.

---
 rtl/adder_8u_bist_driver.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/adder_8u_bist_driver.sv
// Self-test driver for the registered 8-bit adder wrappers.
// Drives LFSR operand pairs onto the wrapper, one pair per cycle. After the
// wrapper's fixed latency it compares the returned {cout,sum} against a locally
// computed golden value. It reports pass/fail, the error count and the index of
// the first failing vector.
module adder_8u_bist_driver #(
    parameter int          LATENCY = 2,
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int          COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COUNT_W-1:0] num_vectors,
    output logic [7:0]         a_out,
    output logic [7:0]         b_out,
    input  logic [7:0]         sum_in,
    input  logic               cout_in,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [COUNT_W-1:0] err_count,
    output logic [COUNT_W-1:0] first_err_idx
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state_reg, state_next;
    logic [15:0]        lfsr_reg;
    logic [COUNT_W-1:0] n_reg;
    logic [COUNT_W-1:0] issue_cnt_reg;
    logic [COUNT_W-1:0] check_cnt_reg;
    logic [COUNT_W-1:0] check_cnt_next;

    // Delay line carrying {valid, expected} alongside the wrapper pipeline.
    logic               dl_valid_reg [LATENCY];
    logic [8:0]         dl_exp_reg   [LATENCY];

    logic               start_accept;
    logic               push_valid;
    logic [8:0]         push_exp;
    logic               tail_valid;
    logic               mismatch;
    logic               issue_more;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Control decode, check comparison and next-state selection.
    always_comb begin
        start_accept   = start && (state_reg == IDLE || state_reg == DONE);
        // Golden value comes from the registered outputs so it lines up with
        // exactly what the wrapper sees.
        push_valid     = (state_reg == RUN);
        push_exp       = {1'b0, a_out} + {1'b0, b_out};
        tail_valid     = dl_valid_reg[LATENCY-1];
        mismatch       = tail_valid && ({cout_in, sum_in} != dl_exp_reg[LATENCY-1]);
        check_cnt_next = check_cnt_reg + COUNT_W'(tail_valid);
        issue_more     = (issue_cnt_reg != n_reg);
        state_next     = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start_accept)
                    state_next = (num_vectors == '0) ? DONE : RUN;
            end
            RUN: begin
                // issue_cnt counts vectors already loaded into a_out/b_out.
                if (!issue_more)
                    state_next = DRAIN;
            end
            DRAIN: begin
                if (check_cnt_next == n_reg)
                    state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Operand issue, LFSR advance, check counting and error capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_out         <= '0;
            b_out         <= '0;
            lfsr_reg      <= SEED;
            n_reg         <= '0;
            issue_cnt_reg <= '0;
            check_cnt_reg <= '0;
            err_count     <= '0;
            first_err_idx <= '1;
        end else if (start_accept) begin
            n_reg         <= num_vectors;
            check_cnt_reg <= '0;
            err_count     <= '0;
            first_err_idx <= '1;
            if (num_vectors != '0) begin
                // Vector 0 is the seed itself and must be on the outputs in the
                // first RUN cycle, so it is loaded here and the LFSR moves on.
                a_out         <= SEED[15:8];
                b_out         <= SEED[7:0];
                lfsr_reg      <= lfsr_step(SEED);
                issue_cnt_reg <= COUNT_W'(1);
            end else begin
                a_out         <= '0;
                b_out         <= '0;
                lfsr_reg      <= SEED;
                issue_cnt_reg <= '0;
            end
        end else begin
            if (tail_valid) begin
                check_cnt_reg <= check_cnt_next;
                if (mismatch) begin
                    if (err_count != '1)
                        err_count <= err_count + COUNT_W'(1);
                    if (first_err_idx == '1)
                        first_err_idx <= check_cnt_reg;
                end
            end
            if (state_reg == RUN && issue_more) begin
                a_out         <= lfsr_reg[15:8];
                b_out         <= lfsr_reg[7:0];
                lfsr_reg      <= lfsr_step(lfsr_reg);
                issue_cnt_reg <= issue_cnt_reg + COUNT_W'(1);
            end else begin
                a_out <= '0;
                b_out <= '0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LATENCY; gi++) begin : g_dl
            if (gi == 0) begin : g_head
                // Head stage captures the vector currently being driven.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        dl_valid_reg[gi] <= 1'b0;
                        dl_exp_reg[gi]   <= '0;
                    end else begin
                        dl_valid_reg[gi] <= push_valid;
                        dl_exp_reg[gi]   <= push_exp;
                    end
                end
            end else begin : g_body
                // Later stages shift the expected value toward the compare point.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        dl_valid_reg[gi] <= 1'b0;
                        dl_exp_reg[gi]   <= '0;
                    end else begin
                        dl_valid_reg[gi] <= dl_valid_reg[gi-1];
                        dl_exp_reg[gi]   <= dl_exp_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    // Status outputs follow directly from the state register.
    always_comb begin
        busy = (state_reg == RUN) || (state_reg == DRAIN);
        done = (state_reg == DONE);
        pass = done && (err_count == '0);
    end

endmodule
